// File: rtl/fifo_stream_adapter_pkg.sv
// Shared types for fifo_stream_adapter: skid-buffer occupancy and burst FSM states.
// Burst support is enabled by defining FIFO_STREAM_ADAPTER_BURST_EN.
package fifo_stream_adapter_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occupancy_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } burst_state_t;

endpackage

// File: rtl/fifo_stream_adapter_if.sv
// Bundle of the FIFO read port, output stream and debug state for fifo_stream_adapter.
// Burst ports exist only when FIFO_STREAM_ADAPTER_BURST_EN is defined.
interface fifo_stream_adapter_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  import fifo_stream_adapter_pkg::*;

  localparam int LW = $clog2(DEPTH) + 1;

  logic             fifo_read_enable;
  logic [WIDTH-1:0] fifo_read_data;
  logic             fifo_empty;
  logic [LW-1:0]    fifo_level;

  // A word transfers on a rising edge where stream_valid && stream_ready; once
  // stream_valid is high it stays high, with stream_data/stream_last frozen, until that transfer.
  logic             stream_valid;
  logic [WIDTH-1:0] stream_data;
  logic             stream_ready;

  occupancy_t       dbg_occupancy;

`ifdef FIFO_STREAM_ADAPTER_BURST_EN
  logic [LW-1:0]    burst_length;
  logic             flush;
  logic             stream_last;
  burst_state_t     dbg_burst_state;

  modport master (
    output fifo_read_enable, input fifo_read_data, input fifo_empty, input fifo_level,
    output stream_valid, output stream_data, input stream_ready,
    input burst_length, input flush, output stream_last,
    output dbg_occupancy, output dbg_burst_state
  );

  modport slave (
    input fifo_read_enable, output fifo_read_data, output fifo_empty, output fifo_level,
    input stream_valid, input stream_data, output stream_ready,
    output burst_length, output flush, input stream_last,
    input dbg_occupancy, input dbg_burst_state
  );
`else
  modport master (
    output fifo_read_enable, input fifo_read_data, input fifo_empty, input fifo_level,
    output stream_valid, output stream_data, input stream_ready,
    output dbg_occupancy
  );

  modport slave (
    input fifo_read_enable, output fifo_read_data, output fifo_empty, output fifo_level,
    input stream_valid, input stream_data, output stream_ready,
    input dbg_occupancy
  );
`endif

endinterface

// File: rtl/fifo_stream_adapter_skid_buffer.sv
// Two-entry registered valid/ready buffer (head + skid); can_accept is registered state only,
// so the upstream pop never depends combinationally on out_ready.
module skid_buffer
  import fifo_stream_adapter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             can_accept,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output occupancy_t       occupancy
);

  occupancy_t       occ_q, occ_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             take;

  assign take = (occ_q != EMPTY) && out_ready;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    skid_d = skid_q;
    unique case (occ_q)
      EMPTY: if (push) begin
        occ_d  = ONE;
        head_d = push_data;
      end
      ONE: begin
        if (push && !take) begin
          occ_d  = TWO;
          skid_d = push_data;
        end else if (push && take) begin
          head_d = push_data;
        end else if (take) begin
          occ_d = EMPTY;
        end
      end
      // can_accept is low here, so only a take can happen
      TWO: if (take) begin
        occ_d  = ONE;
        head_d = skid_q;
      end
      default: occ_d = EMPTY;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      occ_q  <= EMPTY;
      head_q <= '0;
      skid_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end

  assign can_accept = (occ_q != TWO);
  assign out_valid  = (occ_q != EMPTY);
  assign out_data   = head_q;
  assign occupancy  = occ_q;

endmodule

// File: rtl/fifo_stream_adapter.sv
// Drains a first-word-fall-through FIFO into a registered valid/ready stream at one word per cycle.
// Define FIFO_STREAM_ADAPTER_BURST_EN for level-gated bursts with stream_last and flush.
module fifo_stream_adapter
  import fifo_stream_adapter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input logic                  clock,
  input logic                  reset,
  fifo_stream_adapter_if.master bus
);

  localparam int LW = $clog2(DEPTH) + 1;
`ifdef FIFO_STREAM_ADAPTER_BURST_EN
  localparam int BW = WIDTH + 1;
`else
  localparam int BW = WIDTH;
`endif

  logic          can_accept;
  logic          drain_allowed;
  logic          pop;
  logic [BW-1:0] in_word;
  logic [BW-1:0] out_word;

  // Reset gates the pop so the FIFO is never popped while the buffer is held cleared
  assign pop = !reset && !bus.fifo_empty && can_accept && drain_allowed;
  assign bus.fifo_read_enable = pop;

`ifdef FIFO_STREAM_ADAPTER_BURST_EN
  localparam logic [LW-1:0] CNT_ONE = {{(LW-1){1'b0}}, 1'b1};

  burst_state_t  state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] eff_len;

  assign eff_len       = (bus.burst_length == '0) ? CNT_ONE : bus.burst_length;
  assign drain_allowed = (state_q == BURST) && (cnt_q != '0);
  assign in_word       = {(state_q == BURST) && (cnt_q == CNT_ONE), bus.fifo_read_data};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.fifo_level >= eff_len) begin
          state_d = BURST;
          cnt_d   = eff_len;
        end else if (bus.flush && !bus.fifo_empty) begin
          state_d = BURST;
          cnt_d   = (bus.fifo_level < eff_len) ? bus.fifo_level : eff_len;
        end
      end
      BURST: begin
        if (pop) cnt_d = cnt_q - 1'b1;
        if (cnt_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.stream_last     = out_word[WIDTH];
  assign bus.dbg_burst_state = state_q;
`else
  logic unused_level;

  assign unused_level  = ^bus.fifo_level;
  assign drain_allowed = 1'b1;
  assign in_word       = bus.fifo_read_data;
`endif

  skid_buffer #(.WIDTH(BW)) u_skid (
    .clock      (clock),
    .reset      (reset),
    .push       (pop),
    .push_data  (in_word),
    .can_accept (can_accept),
    .out_valid  (bus.stream_valid),
    .out_data   (out_word),
    .out_ready  (bus.stream_ready),
    .occupancy  (bus.dbg_occupancy)
  );

  assign bus.stream_data = out_word[WIDTH-1:0];

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// Bench for fifo_stream_adapter: behavioural FWFT FIFO upstream, scoreboard on the stream side.
// Burst and flush scenarios run when FIFO_STREAM_ADAPTER_BURST_EN is defined.
module tb_fifo_stream_adapter;
  import fifo_stream_adapter_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  fifo_stream_adapter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus();

  fifo_stream_adapter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // ---------------- upstream FWFT FIFO model ----------------
  logic [WIDTH-1:0] fifo_q[$];
  logic             f_empty = 1'b1;
  logic [WIDTH-1:0] f_data  = '0;
  logic [LW-1:0]    f_level = '0;
  logic             wr_en   = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  int               pop_log[$];
  int               pop_lvl[$];
  int               illegal_pops = 0;

  assign bus.fifo_empty     = f_empty;
  assign bus.fifo_read_data = f_data;
  assign bus.fifo_level     = f_level;

  always @(posedge clock) begin
    cyc = cyc + 1;
    if (bus.fifo_read_enable) begin
      if (fifo_q.size() == 0) illegal_pops++;
      else begin
        pop_log.push_back(cyc);
        pop_lvl.push_back(fifo_q.size());
        void'(fifo_q.pop_front());
      end
    end
    if (wr_en && fifo_q.size() < DEPTH) fifo_q.push_back(wr_data);
    f_empty <= (fifo_q.size() == 0);
    f_data  <= (fifo_q.size() != 0) ? fifo_q[0] : '0;
    f_level <= LW'(fifo_q.size());
  end

  // ---------------- scoreboard on the stream side ----------------
  logic [WIDTH:0] exp_q[$];
  int             take_log[$];
  bit             mon_en = 1'b0;
  bit             prev_stall = 1'b0;
  logic [WIDTH:0] prev_word = '0;
  logic [WIDTH:0] mon_word;
  logic [WIDTH:0] mon_exp;

  always @(negedge clock) begin
    if (mon_en) begin
`ifdef FIFO_STREAM_ADAPTER_BURST_EN
      mon_word = {bus.stream_last, bus.stream_data};
`else
      mon_word = {1'b0, bus.stream_data};
`endif
      if (prev_stall) begin
        total++;
        if (bus.stream_valid !== 1'b1) begin
          bad++;
          $display("FAIL valid_drop: stream_valid=%b required=1", bus.stream_valid);
        end
        total++;
        if (mon_word !== prev_word) begin
          bad++;
          $display("FAIL stall_hold: word=%h required=%h", mon_word, prev_word);
        end
      end
      if (bus.stream_valid && bus.stream_ready) begin
        take_log.push_back(cyc);
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_word: got=%h required=none", mon_word);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_word !== mon_exp) begin
            bad++;
            $display("FAIL scoreboard: got=%h required=%h", mon_word, mon_exp);
          end
        end
      end
      prev_stall = bus.stream_valid && !bus.stream_ready;
      prev_word  = mon_word;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_word(input logic [WIDTH-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    bus.stream_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (exp_q.size() == 0 && fifo_q.size() == 0 && !bus.stream_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic set_burst_length(input int n);
`ifdef FIFO_STREAM_ADAPTER_BURST_EN
    bus.burst_length = LW'(n);
`else
    if (n < 0) $display("negative burst length ignored");
`endif
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bit ok;
    mon_en = 1'b0;
    #1;
    total++; if (bus.stream_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got=%b required=0", bus.stream_valid); end
    total++; if (bus.stream_data !== 8'h00) begin bad++; $display("FAIL rst_data: got=%h required=00", bus.stream_data); end
    total++; if (bus.fifo_read_enable !== 1'b0) begin bad++; $display("FAIL rst_pop: got=%b required=0", bus.fifo_read_enable); end
    total++; if (bus.dbg_occupancy !== EMPTY) begin bad++; $display("FAIL rst_occ: got=%0d required=%0d", bus.dbg_occupancy, EMPTY); end
`ifdef FIFO_STREAM_ADAPTER_BURST_EN
    total++; if (bus.stream_last !== 1'b0) begin bad++; $display("FAIL rst_last: got=%b required=0", bus.stream_last); end
    total++; if (bus.dbg_burst_state !== IDLE) begin bad++; $display("FAIL rst_fsm: got=%0d required=%0d", bus.dbg_burst_state, IDLE); end
`endif
    tick();
    tick();
    reset = 1'b0;
    set_burst_length(1);
    write_word(8'h20);
    write_word(8'h21);
    write_word(8'h22);
    for (int i = 0; i < 8; i++) tick();
    total++; if (bus.dbg_occupancy !== TWO) begin bad++; $display("FAIL pre_rst_occ: got=%0d required=%0d", bus.dbg_occupancy, TWO); end
    total++; if (bus.stream_data !== 8'h20) begin bad++; $display("FAIL pre_rst_data: got=%h required=20", bus.stream_data); end
    // asynchronous reset in the middle of a cycle
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    total++; if (bus.stream_valid !== 1'b0) begin bad++; $display("FAIL async_valid: got=%b required=0", bus.stream_valid); end
    total++; if (bus.fifo_read_enable !== 1'b0) begin bad++; $display("FAIL async_pop: got=%b required=0", bus.fifo_read_enable); end
    total++; if (bus.dbg_occupancy !== EMPTY) begin bad++; $display("FAIL async_occ: got=%0d required=%0d", bus.dbg_occupancy, EMPTY); end
    tick();
    pop_log.delete();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (pop_log.size() > 0) break;
    end
    total++; if (pop_log.size() != 1) begin bad++; $display("FAIL post_rst_pop: pops=%0d required=1", pop_log.size()); end
    total++; if (bus.dbg_occupancy !== ONE) begin bad++; $display("FAIL post_rst_occ: got=%0d required=%0d", bus.dbg_occupancy, ONE); end
    total++; if (bus.stream_data !== 8'h22) begin bad++; $display("FAIL post_rst_data: got=%h required=22", bus.stream_data); end
    wait_drain(ok);
    total++; if (!ok) begin bad++; $display("FAIL rst_drain: timeout=1 required=0"); end
  endtask

  task automatic test_throughput();
    bit ok;
    bus.stream_ready = 1'b1;
    set_burst_length(4);
    pop_log.delete();
    take_log.delete();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({(i == 3) ? 1'b1 : 1'b0, 8'(8'h10 + i)});
`ifndef FIFO_STREAM_ADAPTER_BURST_EN
      exp_q[exp_q.size()-1][WIDTH] = 1'b0;
`endif
      write_word(8'(8'h10 + i));
    end
    for (int i = 0; i < 30; i++) begin
      if (take_log.size() >= 4) break;
      tick();
    end
    total++;
    if (take_log.size() != 4 || pop_log.size() != 4) begin
      bad++;
      $display("FAIL tput_count: takes=%0d pops=%0d required=4", take_log.size(), pop_log.size());
    end else begin
      total++; if (pop_log[3] - pop_log[0] != 3) begin bad++; $display("FAIL tput_pops: span=%0d required=3", pop_log[3] - pop_log[0]); end
      total++; if (take_log[3] - take_log[0] != 3) begin bad++; $display("FAIL tput_takes: span=%0d required=3", take_log[3] - take_log[0]); end
      total++; if (bus.stream_valid !== 1'b0) begin bad++; $display("FAIL tput_valid_drop: got=%b required=0", bus.stream_valid); end
    end
    wait_drain(ok);
    total++; if (!ok) begin bad++; $display("FAIL tput_drain: timeout=1 required=0"); end
  endtask

  task automatic test_backpressure();
    bit ok;
    bus.stream_ready = 1'b0;
    set_burst_length(3);
    pop_log.delete();
    take_log.delete();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({(i == 2) ? 1'b1 : 1'b0, 8'(8'h10 + i)});
`ifndef FIFO_STREAM_ADAPTER_BURST_EN
      exp_q[exp_q.size()-1][WIDTH] = 1'b0;
`endif
      write_word(8'(8'h10 + i));
    end
    for (int i = 0; i < 8; i++) tick();
    total++; if (pop_log.size() != 2) begin bad++; $display("FAIL bp_pops: got=%0d required=2", pop_log.size()); end
    total++; if (bus.fifo_read_enable !== 1'b0) begin bad++; $display("FAIL bp_pop_en: got=%b required=0", bus.fifo_read_enable); end
    total++; if (bus.stream_data !== 8'h10) begin bad++; $display("FAIL bp_data: got=%h required=10", bus.stream_data); end
    total++; if (bus.dbg_occupancy !== TWO) begin bad++; $display("FAIL bp_occ: got=%0d required=%0d", bus.dbg_occupancy, TWO); end
    wait_drain(ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_drain: timeout=1 required=0"); end
    total++; if (take_log.size() != 3) begin bad++; $display("FAIL bp_takes: got=%0d required=3", take_log.size()); end
  endtask

`ifdef FIFO_STREAM_ADAPTER_BURST_EN
  task automatic test_burst();
    bit ok;
    bus.stream_ready = 1'b1;
    bus.burst_length = LW'(3);
    pop_log.delete();
    pop_lvl.delete();
    take_log.delete();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({(i == 2) ? 1'b1 : 1'b0, 8'(8'h30 + i)});
      write_word(8'(8'h30 + i));
      for (int k = 0; k < 3; k++) tick();
      if (i < 2) begin
        total++; if (pop_log.size() != 0) begin bad++; $display("FAIL burst_early_pop: pops=%0d required=0", pop_log.size()); end
      end
    end
    for (int i = 0; i < 20; i++) begin
      if (take_log.size() >= 3) break;
      tick();
    end
    total++;
    if (pop_lvl.size() != 3) begin
      bad++;
      $display("FAIL burst_pops: got=%0d required=3", pop_lvl.size());
    end else begin
      total++; if (pop_lvl[0] != 3) begin bad++; $display("FAIL burst_level: got=%0d required=3", pop_lvl[0]); end
      total++; if (pop_log[2] - pop_log[0] != 2) begin bad++; $display("FAIL burst_span: got=%0d required=2", pop_log[2] - pop_log[0]); end
    end
    wait_drain(ok);
    total++; if (!ok) begin bad++; $display("FAIL burst_drain: timeout=1 required=0"); end
    total++; if (bus.dbg_burst_state !== IDLE) begin bad++; $display("FAIL burst_idle: got=%0d required=%0d", bus.dbg_burst_state, IDLE); end
  endtask

  task automatic test_flush();
    bit ok;
    bus.stream_ready = 1'b1;
    bus.burst_length = LW'(4);
    pop_log.delete();
    take_log.delete();
    exp_q.push_back({1'b0, 8'h40});
    exp_q.push_back({1'b1, 8'h41});
    write_word(8'h40);
    write_word(8'h41);
    for (int i = 0; i < 4; i++) tick();
    total++; if (pop_log.size() != 0) begin bad++; $display("FAIL flush_early_pop: pops=%0d required=0", pop_log.size()); end
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (take_log.size() >= 2) break;
      tick();
    end
    total++; if (pop_log.size() != 2) begin bad++; $display("FAIL flush_pops: got=%0d required=2", pop_log.size()); end
    total++; if (bus.dbg_burst_state !== IDLE) begin bad++; $display("FAIL flush_idle: got=%0d required=%0d", bus.dbg_burst_state, IDLE); end
    wait_drain(ok);
    total++; if (!ok) begin bad++; $display("FAIL flush_drain: timeout=1 required=0"); end
  endtask
`endif

  task automatic test_random();
    bit ok;
    int sent;
    logic [WIDTH-1:0] d;
    sent = 0;
    set_burst_length(1);
    take_log.delete();
    illegal_pops = 0;
    for (int i = 0; i < 20000 && sent < 500; i++) begin
      bus.stream_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1 && fifo_q.size() < DEPTH) begin
        d = 8'($urandom_range(0, 255));
        wr_en   = 1'b1;
        wr_data = d;
`ifdef FIFO_STREAM_ADAPTER_BURST_EN
        exp_q.push_back({1'b1, d});
`else
        exp_q.push_back({1'b0, d});
`endif
        sent++;
      end else begin
        wr_en = 1'b0;
      end
      tick();
    end
    wr_en = 1'b0;
    wait_drain(ok);
    total++; if (!ok) begin bad++; $display("FAIL rand_drain: timeout=1 left=%0d required=0", exp_q.size()); end
    total++; if (take_log.size() != 500) begin bad++; $display("FAIL rand_takes: got=%0d required=500", take_log.size()); end
    total++; if (illegal_pops != 0) begin bad++; $display("FAIL rand_empty_pop: got=%0d required=0", illegal_pops); end
  endtask

  initial begin
    bus.stream_ready = 1'b0;
`ifdef FIFO_STREAM_ADAPTER_BURST_EN
    bus.burst_length = LW'(1);
    bus.flush        = 1'b0;
`endif
    test_reset();
    mon_en = 1'b1;
    test_throughput();
    test_backpressure();
`ifdef FIFO_STREAM_ADAPTER_BURST_EN
    test_burst();
    test_flush();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
